// File: rtl/emblem_seq_if.sv
// Frame-level control and status bundle between the video timing block and the emblem sequencer.
interface emblem_seq_if;
    logic       frame_tick;
    logic       start;
    logic       abort;
    logic       emblem_visible;
    logic [9:0] y_shift;
    logic       lion_on;
    logic       busy;
    logic [2:0] state;

    modport master (
        output frame_tick, start, abort,
        input  emblem_visible, y_shift, lion_on, busy, state
    );

    modport slave (
        input  frame_tick, start, abort,
        output emblem_visible, y_shift, lion_on, busy, state
    );
endinterface

// File: rtl/emblem_sequencer.sv
// Shield-emblem overlay sequencer: slide-in, hold, lion blink, slide-out.
// Every visible update happens on frame_tick so the overlay never tears mid-frame.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | emblem hidden, parked SLIDE_START lines below nominal
// SLIDE_IN  | visible, shift shrinking by SLIDE_STEP per frame
// HOLD      | at nominal position for HOLD_FRAMES frames
// BLINK     | lion colour toggles every BLINK_PERIOD frames, BLINK_FRAMES total
// SLIDE_OUT | shift growing back to SLIDE_START, then hidden
module emblem_sequencer #(
    parameter int SLIDE_START  = 240,
    parameter int SLIDE_STEP   = 4,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 32,
    parameter int BLINK_PERIOD = 8
) (
    input  logic         clk,
    input  logic         rst,
    emblem_seq_if.slave  sif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SLIDE_IN  = 3'd1,
        HOLD      = 3'd2,
        BLINK     = 3'd3,
        SLIDE_OUT = 3'd4
    } state_t;

    localparam logic [9:0]  START_Y  = 10'(SLIDE_START);
    // Any step of 1023 or more saturates in one frame, so clamping keeps the math in 11 bits.
    localparam logic [10:0] STEP_X   = 11'((SLIDE_STEP > 1023) ? 1023 : SLIDE_STEP);
    localparam logic [7:0]  HOLD_LD  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0]  BLINK_LD = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0]  PER_LD   = 8'(BLINK_PERIOD - 1);

    state_t      state_q;
    logic        visible_q;
    logic        lion_q;
    logic        busy_q;
    logic [9:0]  y_q;
    logic [7:0]  frame_tmr;
    logic [7:0]  blink_tmr;
    logic        abort_pend;
    logic        abort_now;
    logic [10:0] y_up;

    // An abort arriving on the tick cycle itself still counts for that tick.
    assign abort_now = abort_pend | sif.abort;
    assign y_up      = {1'b0, y_q} + STEP_X;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            visible_q  <= 1'b0;
            lion_q     <= 1'b1;
            busy_q     <= 1'b0;
            y_q        <= START_Y;
            frame_tmr  <= '0;
            blink_tmr  <= '0;
            abort_pend <= 1'b0;
        end else begin
            if (sif.frame_tick)
                abort_pend <= 1'b0;
            else if (sif.abort)
                abort_pend <= 1'b1;

            if (sif.frame_tick) begin
                case (state_q)
                    IDLE: begin
                        if (sif.start && !abort_now) begin
                            state_q   <= SLIDE_IN;
                            visible_q <= 1'b1;
                            busy_q    <= 1'b1;
                            y_q       <= START_Y;
                        end
                    end
                    SLIDE_IN: begin
                        if (abort_now) begin
                            state_q <= SLIDE_OUT;
                            lion_q  <= 1'b1;
                        end else if ({1'b0, y_q} <= STEP_X) begin
                            y_q       <= '0;
                            state_q   <= HOLD;
                            frame_tmr <= HOLD_LD;
                        end else begin
                            y_q <= y_q - STEP_X[9:0];
                        end
                    end
                    HOLD: begin
                        if (abort_now) begin
                            state_q <= SLIDE_OUT;
                            lion_q  <= 1'b1;
                        end else if (frame_tmr == 8'd0) begin
                            state_q   <= BLINK;
                            frame_tmr <= BLINK_LD;
                            blink_tmr <= PER_LD;
                        end else begin
                            frame_tmr <= frame_tmr - 8'd1;
                        end
                    end
                    BLINK: begin
                        if (abort_now || frame_tmr == 8'd0) begin
                            state_q <= SLIDE_OUT;
                            lion_q  <= 1'b1;
                        end else begin
                            frame_tmr <= frame_tmr - 8'd1;
                            if (blink_tmr == 8'd0) begin
                                lion_q    <= ~lion_q;
                                blink_tmr <= PER_LD;
                            end else begin
                                blink_tmr <= blink_tmr - 8'd1;
                            end
                        end
                    end
                    SLIDE_OUT: begin
                        if (y_up >= {1'b0, START_Y}) begin
                            y_q       <= START_Y;
                            state_q   <= IDLE;
                            visible_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end else begin
                            y_q <= y_up[9:0];
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        visible_q <= 1'b0;
                        busy_q    <= 1'b0;
                        lion_q    <= 1'b1;
                        y_q       <= START_Y;
                    end
                endcase
            end
        end
    end

    assign sif.state          = state_q;
    assign sif.emblem_visible = visible_q;
    assign sif.y_shift        = y_q;
    assign sif.lion_on        = lion_q;
    assign sif.busy           = busy_q;

endmodule

// File: tb/tb_emblem_sequencer.sv
// Bench for emblem_sequencer: two instances (step 4 and step 7) on shared stimulus,
// checked every cycle against a frame-level model plus hand-computed milestones.
module tb_emblem_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_tick = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    always #5 clk = ~clk;

    emblem_seq_if if_a ();
    emblem_seq_if if_b ();

    assign if_a.frame_tick = frame_tick;
    assign if_a.start      = start;
    assign if_a.abort      = abort;
    assign if_b.frame_tick = frame_tick;
    assign if_b.start      = start;
    assign if_b.abort      = abort;

    emblem_sequencer dut_a (.clk(clk), .rst(rst), .sif(if_a.slave));
    emblem_sequencer #(.SLIDE_STEP(7)) dut_b (.clk(clk), .rst(rst), .sif(if_b.slave));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        int   st;
        logic vis;
        int   y;
        logic lion;
        int   cnt;
        logic pend;
    } m_t;

    function automatic m_t m_reset(int ss);
        m_t m;
        m.st = 0; m.vis = 1'b0; m.y = ss; m.lion = 1'b1; m.cnt = 0; m.pend = 1'b0;
        return m;
    endfunction

    // One frame_tick worth of sequencing, straight from the frame-level rules.
    function automatic m_t m_tick(m_t m, logic st_in, logic ab, int ss, int step,
                                  int hf, int bf, int bp);
        m_t  n;
        logic ab_eff;
        n      = m;
        ab_eff = m.pend | ab;
        n.pend = 1'b0;
        case (m.st)
            0: if (st_in && !ab_eff) begin n.st = 1; n.vis = 1'b1; n.y = ss; end
            1: begin
                if (ab_eff) begin n.st = 4; n.lion = 1'b1; n.cnt = 0; end
                else begin
                    n.y = (m.y - step < 0) ? 0 : m.y - step;
                    if (n.y == 0) begin n.st = 2; n.cnt = 0; end
                end
            end
            2: begin
                if (ab_eff) begin n.st = 4; n.lion = 1'b1; n.cnt = 0; end
                else if (m.cnt == hf - 1) begin n.st = 3; n.cnt = 0; end
                else n.cnt = m.cnt + 1;
            end
            3: begin
                if (ab_eff) begin n.st = 4; n.lion = 1'b1; n.cnt = 0; end
                else begin
                    if ((m.cnt + 1) % bp == 0) n.lion = ~m.lion;
                    if (m.cnt == bf - 1) begin n.st = 4; n.lion = 1'b1; n.cnt = 0; end
                    else n.cnt = m.cnt + 1;
                end
            end
            4: begin
                n.y = (m.y + step > ss) ? ss : m.y + step;
                if (n.y == ss) begin n.st = 0; n.vis = 1'b0; end
            end
            default: n = m_reset(ss);
        endcase
        return n;
    endfunction

    m_t ma, mb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= m_reset(240);
            mb <= m_reset(240);
        end else if (frame_tick) begin
            ma <= m_tick(ma, start, abort, 240, 4, 120, 32, 8);
            mb <= m_tick(mb, start, abort, 240, 7, 120, 32, 8);
        end else begin
            ma.pend <= ma.pend | abort;
            mb.pend <= mb.pend | abort;
        end
    end

    task automatic check_model(string name, logic [2:0] st, logic vis, logic [9:0] y,
                               logic lion, logic busy, m_t m);
        n_cmp++;
        if (st !== 3'(m.st) || vis !== m.vis || y !== 10'(m.y) || lion !== m.lion ||
            busy !== (m.st != 0)) begin
            n_bad++;
            $display("FAIL %s t=%0t: got st=%0d vis=%0b y=%0d lion=%0b busy=%0b, expected st=%0d vis=%0b y=%0d lion=%0b busy=%0b",
                     name, $time, st, vis, y, lion, busy, m.st, m.vis, m.y, m.lion, m.st != 0);
        end
    endtask

    always @(negedge clk) begin
        check_model("model_a", if_a.state, if_a.emblem_visible, if_a.y_shift, if_a.lion_on, if_a.busy, ma);
        check_model("model_b", if_b.state, if_b.emblem_visible, if_b.y_shift, if_b.lion_on, if_b.busy, mb);
    end

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ticks(int n);
        repeat (n) begin
            @(negedge clk); frame_tick = 1'b1;
            @(negedge clk); frame_tick = 1'b0;
        end
    endtask

    task automatic launch();
        @(negedge clk); start = 1'b1; frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    int total;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ticks(3);
        check("rst_state", int'(if_a.state), 0);
        check("rst_vis", int'(if_a.emblem_visible), 0);
        check("rst_y", int'(if_a.y_shift), 240);
        check("rst_lion", int'(if_a.lion_on), 1);
        check("rst_busy", int'(if_a.busy), 0);

        // Full run with start held high throughout.
        launch();
        total = 1;
        check("launch_state", int'(if_a.state), 1);
        check("launch_y", int'(if_a.y_shift), 240);
        check("launch_vis", int'(if_a.emblem_visible), 1);
        ticks(34); total += 34;
        check("step7_y_2", int'(if_b.y_shift), 2);
        check("step7_state_in", int'(if_b.state), 1);
        ticks(1); total += 1;
        check("step7_y_sat", int'(if_b.y_shift), 0);
        check("step7_hold", int'(if_b.state), 2);
        ticks(25); total += 25;
        check("slide_in_y", int'(if_a.y_shift), 0);
        check("slide_in_hold", int'(if_a.state), 2);
        ticks(120); total += 120;
        check("blink_enter", int'(if_a.state), 3);
        check("blink_lion0", int'(if_a.lion_on), 1);
        ticks(8); total += 8;
        check("blink_lion8", int'(if_a.lion_on), 0);
        ticks(8); total += 8;
        check("blink_lion16", int'(if_a.lion_on), 1);
        while (if_a.state != 3'd0 && total < 400) begin
            ticks(1);
            total++;
        end
        check("full_run_ticks", total, 273);
        check("full_run_vis", int'(if_a.emblem_visible), 0);
        check("full_run_y", int'(if_a.y_shift), 240);
        ticks(1);
        check("relaunch", int'(if_a.state), 1);
        start = 1'b0;

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        ticks(2);

        // Abort pulse mid-frame during HOLD.
        launch(); start = 1'b0;
        ticks(60);
        check("abort_pre_hold", int'(if_a.state), 2);
        ticks(50);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_waits_tick", int'(if_a.state), 2);
        ticks(1);
        check("abort_state", int'(if_a.state), 4);
        check("abort_y", int'(if_a.y_shift), 0);
        check("abort_lion", int'(if_a.lion_on), 1);
        ticks(59);
        check("slide_out_y", int'(if_a.y_shift), 236);
        ticks(1);
        check("slide_out_idle", int'(if_a.state), 0);
        check("slide_out_y_end", int'(if_a.y_shift), 240);

        // Abort and start on the same idle tick.
        @(negedge clk); start = 1'b1; abort = 1'b1; frame_tick = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0; frame_tick = 1'b0;
        check("abort_start_same", int'(if_a.state), 0);
        check("abort_start_busy", int'(if_a.busy), 0);

        // Abort latched a few cycles before the tick still blocks the launch.
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        @(negedge clk); start = 1'b1; frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        check("pend_blocks", int'(if_a.state), 0);
        ticks(1);
        check("pend_cleared", int'(if_a.state), 1);
        start = 1'b0;

        // Abort straight out of SLIDE_IN keeps the shift, then parks.
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        ticks(1);
        check("abort_in_state", int'(if_a.state), 4);
        check("abort_in_y", int'(if_a.y_shift), 240);
        ticks(1);
        check("abort_in_idle", int'(if_a.state), 0);

        // Asynchronous reset in BLINK while the lions are off.
        launch(); start = 1'b0;
        ticks(188);
        check("pre_rst_state", int'(if_a.state), 3);
        check("pre_rst_lion", int'(if_a.lion_on), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_state", int'(if_a.state), 0);
        check("async_vis", int'(if_a.emblem_visible), 0);
        check("async_lion", int'(if_a.lion_on), 1);
        check("async_busy", int'(if_a.busy), 0);
        check("async_y", int'(if_a.y_shift), 240);
        @(negedge clk); rst = 1'b0;
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
